// File: rtl/pc_src_mux_if.sv
// Bundle for the PC source selector: select/candidate inputs, stall, and the
// combinational and registered PC-side outputs.
interface pc_src_mux_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             mPCSel;
    logic [WIDTH-1:0] pResult;
    logic [WIDTH-1:0] bResult;
    logic             stall;
    logic [WIDTH-1:0] pSource;
    logic [WIDTH-1:0] pcQ;
    logic             misaligned;
    logic             redirect;
    logic [CNT_W-1:0] selCount;

    modport master (
        output mPCSel,
        output pResult,
        output bResult,
        output stall,
        input  pSource,
        input  pcQ,
        input  misaligned,
        input  redirect,
        input  selCount
    );

    modport slave (
        input  mPCSel,
        input  pResult,
        input  bResult,
        input  stall,
        output pSource,
        output pcQ,
        output misaligned,
        output redirect,
        output selCount
    );
endinterface

// File: rtl/pc_src_mux.sv
// Next-PC source selector: combinational pick between sequential and branch
// targets, plus the registered PC, a redirect pulse and a saturating taken count.
module pc_src_mux #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int               CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_src_mux_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    function automatic logic addr_misaligned(input logic [WIDTH-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    logic [WIDTH-1:0] psource_s;
    logic             sel_branch_s;
    logic             misaligned_s;
    logic [CNT_W-1:0] sel_count_nxt_s;

    logic [WIDTH-1:0] pc_r;
    logic             redirect_r;
    logic [CNT_W-1:0] sel_count_r;

    // Source select; anything other than a clean 1 falls back to the sequential path.
    always_comb begin
        psource_s    = bus.pResult;
        sel_branch_s = 1'b0;
        case (bus.mPCSel)
            1'b1: begin
                psource_s    = bus.bResult;
                sel_branch_s = 1'b1;
            end
            default: begin
                psource_s    = bus.pResult;
                sel_branch_s = 1'b0;
            end
        endcase
    end

    // Alignment flag is informational only and never gates the register update.
    always_comb begin
        misaligned_s = addr_misaligned(psource_s);
    end

    // Saturating taken-select count candidate.
    always_comb begin
        sel_count_nxt_s = sel_count_r;
        if (sel_branch_s && (sel_count_r != CNT_MAX)) begin
            sel_count_nxt_s = sel_count_r + CNT_ONE;
        end else begin
            sel_count_nxt_s = sel_count_r;
        end
    end

    // PC, redirect and count registers; reset outranks stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r        <= RESET_PC;
            redirect_r  <= 1'b0;
            sel_count_r <= CNT_ZERO;
        end else if (bus.stall) begin
            redirect_r  <= 1'b0;
        end else begin
            pc_r        <= psource_s;
            redirect_r  <= sel_branch_s;
            sel_count_r <= sel_count_nxt_s;
        end
    end

    assign bus.pSource    = psource_s;
    assign bus.misaligned = misaligned_s;
    assign bus.pcQ        = pc_r;
    assign bus.redirect   = redirect_r;
    assign bus.selCount   = sel_count_r;

endmodule

// File: tb/tb_pc_src_mux.sv
// Scoreboard bench for pc_src_mux: directed scenarios plus a randomized
// back-to-back run, with a narrow-counter instance for saturation.
module tb_pc_src_mux;

    localparam logic [31:0] RESET_PC = 32'h0000_0A00;

    logic clk         = 1'b0;
    logic clk_en      = 1'b1;
    logic rst_n       = 1'b0;
    logic rst_n_small = 1'b0;

    always #5 clk = clk_en ? ~clk : clk;

    pc_src_mux_if #(.WIDTH(32), .CNT_W(16)) bus ();
    pc_src_mux_if #(.WIDTH(32), .CNT_W(2))  sbus ();

    pc_src_mux #(.WIDTH(32), .RESET_PC(RESET_PC), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pc_src_mux #(.WIDTH(32), .RESET_PC(32'h0000_0000), .CNT_W(2)) dut_small (
        .clk   (clk),
        .rst_n (rst_n_small),
        .bus   (sbus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic        redir;
        logic [15:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] sat_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic drive(input logic r, input logic st, input logic sel,
                         input logic [31:0] p, input logic [31:0] b);
        rst_n       = r;
        bus.stall   = st;
        bus.mPCSel  = sel;
        bus.pResult = p;
        bus.bResult = b;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic redir, input logic [15:0] cnt);
        exp_t e;
        e.pc    = pc;
        e.redir = redir;
        e.cnt   = cnt;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        logic        r[3]    = '{1'b0, 1'b0, 1'b1};
        logic        s[3]    = '{1'b1, 1'b0, 1'b0};
        logic [31:0] epc[3]  = '{RESET_PC, RESET_PC, 32'd400};
        logic        ered[3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] ecnt[3] = '{16'd0, 16'd0, 16'd1};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(r[i], s[i], 1'b1, 32'd500, 32'd400);
            push_exp(epc[i], ered[i], ecnt[i]);
            @(posedge clk);
            #1;
            tests_run++;
            if (bus.pSource !== 32'd400) begin
                tests_failed++;
                $display("FAIL reset_psource[%0d]: got %0d, expected 400", i, bus.pSource);
            end
            e = exp_q.pop_front();
            tests_run++;
            if (bus.pcQ !== e.pc || bus.redirect !== e.redir || bus.selCount !== e.cnt) begin
                tests_failed++;
                $display("FAIL reset[%0d]: got pc=%h redir=%b cnt=%0d, expected pc=%h redir=%b cnt=%0d",
                         i, bus.pcQ, bus.redirect, bus.selCount, e.pc, e.redir, e.cnt);
            end
        end
    endtask

    task automatic test_comb_select();
        @(negedge clk);
        clk_en = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'd500, 32'd400);
        #100;
        tests_run++;
        if (bus.pSource !== 32'd500 || bus.misaligned !== 1'b0) begin
            tests_failed++;
            $display("FAIL comb_sel0: got pSource=%0d mis=%b, expected 500 0", bus.pSource, bus.misaligned);
        end
        bus.mPCSel = 1'b1;
        #1;
        tests_run++;
        if (bus.pSource !== 32'd400 || bus.misaligned !== 1'b0) begin
            tests_failed++;
            $display("FAIL comb_sel1: got pSource=%0d mis=%b, expected 400 0", bus.pSource, bus.misaligned);
        end
        tests_run++;
        if (bus.pcQ !== 32'd400 || bus.selCount !== 16'd1) begin
            tests_failed++;
            $display("FAIL comb_no_edge: got pc=%0d cnt=%0d, expected 400 1", bus.pcQ, bus.selCount);
        end
        clk_en = 1'b1;
    endtask

    task automatic test_stall();
        logic        st[5]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] b[5]    = '{32'h80, 32'h100, 32'h100, 32'h100, 32'h100};
        logic [31:0] epc[5]  = '{32'h80, 32'h80, 32'h80, 32'h80, 32'h100};
        logic        ered[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] ecnt[5] = '{16'd2, 16'd2, 16'd2, 16'd2, 16'd3};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, st[i], 1'b1, 32'h44, b[i]);
            push_exp(epc[i], ered[i], ecnt[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (bus.pcQ !== e.pc || bus.redirect !== e.redir || bus.selCount !== e.cnt) begin
                tests_failed++;
                $display("FAIL stall[%0d]: got pc=%h redir=%b cnt=%0d, expected pc=%h redir=%b cnt=%0d",
                         i, bus.pcQ, bus.redirect, bus.selCount, e.pc, e.redir, e.cnt);
            end
        end
    endtask

    task automatic test_misaligned();
        logic        sel[3]  = '{1'b0, 1'b1, 1'b1};
        logic [31:0] p[3]    = '{32'h102, 32'h104, 32'h105};
        logic [31:0] b[3]    = '{32'h200, 32'h203, 32'h208};
        logic [31:0] epc[3]  = '{32'h102, 32'h203, 32'h208};
        logic        emis[3] = '{1'b1, 1'b1, 1'b0};
        logic        ered[3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] ecnt[3] = '{16'd3, 16'd4, 16'd5};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, sel[i], p[i], b[i]);
            push_exp(epc[i], ered[i], ecnt[i]);
            #1;
            tests_run++;
            if (bus.misaligned !== emis[i] || bus.pSource !== epc[i]) begin
                tests_failed++;
                $display("FAIL misaligned_comb[%0d]: got mis=%b pSource=%h, expected %b %h",
                         i, bus.misaligned, bus.pSource, emis[i], epc[i]);
            end
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (bus.pcQ !== e.pc || bus.redirect !== e.redir || bus.selCount !== e.cnt) begin
                tests_failed++;
                $display("FAIL misaligned_reg[%0d]: got pc=%h redir=%b cnt=%0d, expected pc=%h redir=%b cnt=%0d",
                         i, bus.pcQ, bus.redirect, bus.selCount, e.pc, e.redir, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] m_pc  = RESET_PC;
        logic        m_red = 1'b0;
        logic [15:0] m_cnt = 16'd0;
        logic        r, st, sel;
        logic [31:0] p, b, exp_src;
        exp_t e;
        for (int i = 0; i < 160; i++) begin
            r   = (i == 0) ? 1'b0 : ($urandom_range(0, 19) != 0);
            st  = ($urandom_range(0, 3) == 0);
            sel = (i < 40) ? i[0] : 1'($urandom_range(0, 1));
            p   = $urandom;
            b   = $urandom;
            exp_src = sel ? b : p;
            drive(r, st, sel, p, b);
            if (!r) begin
                m_pc  = RESET_PC;
                m_red = 1'b0;
                m_cnt = 16'd0;
            end else if (st) begin
                m_red = 1'b0;
            end else begin
                m_pc  = exp_src;
                m_red = sel;
                if (sel && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            push_exp(m_pc, m_red, m_cnt);
            #1;
            tests_run++;
            if (bus.pSource !== exp_src || bus.misaligned !== (exp_src[1:0] != 2'b00)) begin
                tests_failed++;
                $display("FAIL b2b_comb[%0d]: got pSource=%h mis=%b, expected %h %b",
                         i, bus.pSource, bus.misaligned, exp_src, (exp_src[1:0] != 2'b00));
            end
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (bus.pcQ !== e.pc || bus.redirect !== e.redir || bus.selCount !== e.cnt) begin
                tests_failed++;
                $display("FAIL b2b_reg[%0d]: got pc=%h redir=%b cnt=%0d, expected pc=%h redir=%b cnt=%0d",
                         i, bus.pcQ, bus.redirect, bus.selCount, e.pc, e.redir, e.cnt);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] seq[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [1:0] got;
        bus.stall     = 1'b1;
        sbus.stall    = 1'b0;
        sbus.mPCSel   = 1'b1;
        sbus.pResult  = 32'h0000_0020;
        sbus.bResult  = 32'h0000_0010;
        for (int i = 0; i < 6; i++) begin
            rst_n_small = (i != 0);
            sat_q.push_back(seq[i]);
            @(posedge clk);
            #1;
            got = sat_q.pop_front();
            tests_run++;
            if (sbus.selCount !== got) begin
                tests_failed++;
                $display("FAIL saturation[%0d]: got selCount=%0d, expected %0d", i, sbus.selCount, got);
            end
        end
        tests_run++;
        if (sbus.pcQ !== 32'h0000_0010 || sbus.redirect !== 1'b1) begin
            tests_failed++;
            $display("FAIL saturation_pc: got pc=%h redir=%b, expected 00000010 1", sbus.pcQ, sbus.redirect);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_comb_select();
        test_stall();
        test_misaligned();
        test_back_to_back();
        test_saturation();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
